set_member_scanner: RTL and testbench

- Sequential membership engine: holds an unpacked table of DEPTH words and answers "is key in table" queries by scanning one entry per clock.
- Upstream side is a table write port plus a query valid/ready handshake. Downstream side is a one-cycle result strobe with hit flag and matching index.
- It is the multi-cycle, hardware-shaped counterpart of a set-membership check over an unpacked array. It feeds a consumer that branches on the hit/miss result.

---
 rtl/set_member_scanner_if.sv | 29 ++
 rtl/set_member_scanner.sv | 100 ++++++++++
 tb/tb_set_member_scanner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/set_member_scanner_if.sv
// Query/result and table-write bundle for set_member_scanner.
// The master side is the upstream requester. The slave side is the engine.
interface set_member_scanner_if #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
);
  localparam int IW = $clog2(DEPTH);

  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             q_valid;
  logic             q_ready;
  logic [WIDTH-1:0] q_key;
  logic             r_valid;
  logic             r_hit;
  logic [IW-1:0]    r_idx;
  logic             busy;

  modport master (
    output wr_en, wr_idx, wr_data, q_valid, q_key,
    input  q_ready, r_valid, r_hit, r_idx, busy
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, q_valid, q_key,
    output q_ready, r_valid, r_hit, r_idx, busy
  );
endinterface

// File: rtl/set_member_scanner.sv
// Membership scanner: one entry per clock, result strobe k+1 cycles after accept (DEPTH on miss); q_ready low until RESP ends.
// Optional per-entry valid bits under SET_MEMBER_SCANNER_VALID_MASK_EN.
module set_member_scanner #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  set_member_scanner_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t           state;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] key_q;
  logic [IW-1:0]    idx_q;
  logic             wr_ok;
  logic             match;

  // Out-of-range write indices are dropped entirely.
  assign wr_ok = bus.wr_en && (int'(bus.wr_idx) < DEPTH);

`ifdef SET_MEMBER_SCANNER_VALID_MASK_EN
  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (wr_ok) begin
      vld_q[bus.wr_idx] <= 1'b1;
    end
  end

  assign match = vld_q[idx_q] && (tbl_q[idx_q] == key_q);
`else
  assign match = (tbl_q[idx_q] == key_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
    end else if (wr_ok) begin
      tbl_q[bus.wr_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_q       <= '0;
      idx_q       <= '0;
      bus.q_ready <= 1'b1;
      bus.r_valid <= 1'b0;
      bus.r_hit   <= 1'b0;
      bus.r_idx   <= '0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.q_valid) begin
            key_q       <= bus.q_key;
            idx_q       <= '0;
            state       <= SCAN;
            bus.q_ready <= 1'b0;
            bus.busy    <= 1'b1;
          end
        end
        SCAN: begin
          if (match) begin
            bus.r_hit   <= 1'b1;
            bus.r_idx   <= idx_q;
            bus.r_valid <= 1'b1;
            state       <= RESP;
          end else if (idx_q == IW'(DEPTH - 1)) begin
            bus.r_hit   <= 1'b0;
            bus.r_idx   <= '0;
            bus.r_valid <= 1'b1;
            state       <= RESP;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        RESP: begin
          bus.r_valid <= 1'b0;
          bus.q_ready <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          bus.r_valid <= 1'b0;
          bus.q_ready <= 1'b1;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_set_member_scanner.sv
// Directed, table-driven bench for set_member_scanner (DEPTH=10, WIDTH=32).
module tb_set_member_scanner;
  logic clk = 1'b0;
  logic rst;

  set_member_scanner_if #(.DEPTH(10), .WIDTH(32)) bus ();

  set_member_scanner #(.DEPTH(10), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    logic        hit;
    logic [3:0]  idx;
    int          lat;
  } vec_t;

  vec_t vec [5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int res_cyc = 0;
  int n_pulse = 0;
  int n_acc = 0;
  logic       log_hit [8];
  logic [3:0] log_idx [8];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.q_valid && bus.q_ready) n_acc = n_acc + 1;
  end

  always @(negedge clk) begin
    if (bus.r_valid) begin
      if (n_pulse < 8) begin
        log_hit[n_pulse] = bus.r_hit;
        log_idx[n_pulse] = bus.r_idx;
      end
      res_cyc = cyc;
      n_pulse = n_pulse + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Returns #1 after the accepting posedge with acc_cyc recorded.
  task automatic launch(input logic [31:0] key);
    n_pulse = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.q_ready; i++) @(negedge clk);
    bus.q_valid = 1'b1; bus.q_key = key;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.q_valid = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 20 && n_pulse == 0; i++) @(negedge clk);
    if (n_pulse == 0) check("result_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic query_check(input string name, input logic [31:0] key,
                             input logic hit, input logic [3:0] idx, input int lat);
    launch(key);
    wait_result();
    check({name, "_hit"}, 32'(log_hit[0]), 32'(hit));
    check({name, "_idx"}, 32'(log_idx[0]), 32'(idx));
    check({name, "_lat"}, res_cyc - acc_cyc, lat);
    check({name, "_pulses"}, n_pulse, 1);
  endtask

  initial begin
    vec[0] = '{key: 32'd10, hit: 1'b1, idx: 4'd0, lat: 1};
    vec[1] = '{key: 32'd20, hit: 1'b1, idx: 4'd1, lat: 2};
    vec[2] = '{key: 32'd90, hit: 1'b1, idx: 4'd9, lat: 10};
    vec[3] = '{key: 32'd99, hit: 1'b0, idx: 4'd0, lat: 10};
`ifdef SET_MEMBER_SCANNER_VALID_MASK_EN
    vec[4] = '{key: 32'd0,  hit: 1'b0, idx: 4'd0, lat: 10};
`else
    vec[4] = '{key: 32'd0,  hit: 1'b1, idx: 4'd2, lat: 3};
`endif

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.q_valid = 1'b0; bus.q_key = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q_ready", 32'(bus.q_ready), 1);
    check("rst_r_valid", 32'(bus.r_valid), 0);
    check("rst_r_hit", 32'(bus.r_hit), 0);
    check("rst_r_idx", 32'(bus.r_idx), 0);
    check("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;

    do_write(4'd0, 32'd10);
    do_write(4'd1, 32'd20);
    do_write(4'd9, 32'd90);

    // Busy/ready during a scan
    launch(32'd90);
    @(negedge clk);
    check("scan_busy", 32'(bus.busy), 1);
    check("scan_q_ready", 32'(bus.q_ready), 0);
    wait_result();

    for (int v = 0; v < 5; v++) begin
      query_check($sformatf("vec%0d", v), vec[v].key, vec[v].hit, vec[v].idx, vec[v].lat);
    end

    // Duplicates: lowest index wins
    do_write(4'd3, 32'd55);
    do_write(4'd7, 32'd55);
    query_check("dup55", 32'd55, 1'b1, 4'd3, 4);

    // Write to index 3 on the very edge it is compared: old value still matches
    launch(32'd55);
    repeat (3) @(posedge clk);
    #1;
    bus.wr_en = 1'b1; bus.wr_idx = 4'd3; bus.wr_data = 32'd1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    wait_result();
    check("collide_hit", 32'(log_hit[0]), 1);
    check("collide_idx", 32'(log_idx[0]), 3);
    check("collide_lat", res_cyc - acc_cyc, 4);
    query_check("after_collide", 32'd55, 1'b1, 4'd7, 8);

    // Reset mid-scan aborts and clears the table
    launch(32'd90);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_q_ready", 32'(bus.q_ready), 1);
    check("abort_busy", 32'(bus.busy), 0);
    repeat (12) @(negedge clk);
    check("abort_no_pulse", n_pulse, 0);
    query_check("cleared90", 32'd90, 1'b0, 4'd0, 10);

    // Continuous q_valid with out-of-range writes held throughout
    do_write(4'd0, 32'd10);
    do_write(4'd1, 32'd20);
    @(negedge clk);
    n_pulse = 0; n_acc = 0;
    bus.wr_en = 1'b1; bus.wr_idx = 4'd12; bus.wr_data = 32'd77;
    bus.q_valid = 1'b1; bus.q_key = 32'd10;
    for (int i = 0; i < 20 && n_acc < 1; i++) @(negedge clk);
    bus.q_key = 32'd20;
    for (int i = 0; i < 40 && n_pulse < 2; i++) @(negedge clk);
    bus.q_valid = 1'b0;
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("stream_accepts", n_acc, 2);
    check("stream_pulses", n_pulse, 2);
    check("stream0_hit", 32'(log_hit[0]), 1);
    check("stream0_idx", 32'(log_idx[0]), 0);
    check("stream1_hit", 32'(log_hit[1]), 1);
    check("stream1_idx", 32'(log_idx[1]), 1);
    query_check("ignored77", 32'd77, 1'b0, 4'd0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end
endmodule
